// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions for the ID/EX stage: ALU encodings, register-zero
// specifier, bubble control pattern and the per-edge action of the stage register.
package id_ex_stage_reg_pkg;

  localparam int unsigned ALUOP_W_DEF = 4;
  localparam logic [4:0]  REG_ZERO    = 5'd0;

  // Control bits forced by a bubble: {valid, reg_wen, mem_read, mem_write, jr}
  localparam logic [4:0]  BUBBLE_CTRL = '0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } stage_act_e;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// One pipeline-stage instruction bundle; the ID side is consumed via slave,
// the registered EX side is produced via master.
interface id_ex_stage_reg_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALUOP_W = 4
);
  logic               valid;
  logic [DATA_W-1:0]  pc;
  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic               uses_rt;
  logic [DATA_W-1:0]  imm;
  logic               reg_wen;
  logic               mem_read;
  logic               mem_write;
  logic               alu_src;
  logic               jr;
  logic [ALUOP_W-1:0] alu_op;

  modport master (
    output valid, pc, rs_data, rt_data, rs, rt, rd, uses_rt, imm,
           reg_wen, mem_read, mem_write, alu_src, jr, alu_op
  );

  modport slave (
    input  valid, pc, rs_data, rt_data, rs, rt, rd, uses_rt, imm,
           reg_wen, mem_read, mem_write, alu_src, jr, alu_op
  );
endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose destination is read
// by the instruction in ID. A load into $0 never creates a dependency.
module id_load_use_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rd == id_rs);
  assign rt_match = id_uses_rt & (ex_rd == id_rt);
  assign load_use = ex_valid & ex_mem_read & (ex_rd != REG_ZERO) & id_valid &
                    (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and EX-stall
// handling, plus a saturating count of inserted bubbles.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALUOP_W = ALUOP_W_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_stage_reg_if.slave  id_bus,
  id_ex_stage_reg_if.master ex_bus,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              stall_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic       load_use;
  stage_act_e act;

  id_load_use_detect u_load_use_detect (
    .ex_valid    (ex_bus.valid),
    .ex_mem_read (ex_bus.mem_read),
    .ex_rd       (ex_bus.rd),
    .id_valid    (id_bus.valid),
    .id_rs       (id_bus.rs),
    .id_rt       (id_bus.rt),
    .id_uses_rt  (id_bus.uses_rt),
    .load_use    (load_use)
  );

  // A flushed ID instruction is dead, so a hazard against it must not stall.
  assign stall_out = ex_stall | (load_use & ~flush);

  always_comb begin
    act = ACT_LOAD;
    if (ex_stall)
      act = ACT_HOLD;
    else if (flush || load_use)
      act = ACT_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_bus.valid     <= 1'b0;
      ex_bus.pc        <= '0;
      ex_bus.rs_data   <= '0;
      ex_bus.rt_data   <= '0;
      ex_bus.rs        <= '0;
      ex_bus.rt        <= '0;
      ex_bus.rd        <= '0;
      ex_bus.uses_rt   <= 1'b0;
      ex_bus.imm       <= '0;
      ex_bus.reg_wen   <= 1'b0;
      ex_bus.mem_read  <= 1'b0;
      ex_bus.mem_write <= 1'b0;
      ex_bus.alu_src   <= 1'b0;
      ex_bus.jr        <= 1'b0;
      ex_bus.alu_op    <= '0;
      bubble_cnt       <= '0;
    end else begin
      unique case (act)
        ACT_LOAD: begin
          ex_bus.valid     <= id_bus.valid;
          ex_bus.pc        <= id_bus.pc;
          ex_bus.rs_data   <= id_bus.rs_data;
          ex_bus.rt_data   <= id_bus.rt_data;
          ex_bus.rs        <= id_bus.rs;
          ex_bus.rt        <= id_bus.rt;
          ex_bus.rd        <= id_bus.rd;
          ex_bus.uses_rt   <= id_bus.uses_rt;
          ex_bus.imm       <= id_bus.imm;
          ex_bus.reg_wen   <= id_bus.reg_wen;
          ex_bus.mem_read  <= id_bus.mem_read;
          ex_bus.mem_write <= id_bus.mem_write;
          ex_bus.alu_src   <= id_bus.alu_src;
          ex_bus.jr        <= id_bus.jr;
          ex_bus.alu_op    <= id_bus.alu_op;
        end
        ACT_BUBBLE: begin
          {ex_bus.valid, ex_bus.reg_wen, ex_bus.mem_read,
           ex_bus.mem_write, ex_bus.jr} <= BUBBLE_CTRL;
          ex_bus.pc        <= '0;
          ex_bus.rs_data   <= '0;
          ex_bus.rt_data   <= '0;
          ex_bus.rs        <= '0;
          ex_bus.rt        <= '0;
          ex_bus.rd        <= '0;
          ex_bus.uses_rt   <= 1'b0;
          ex_bus.imm       <= '0;
          ex_bus.alu_src   <= 1'b0;
          ex_bus.alu_op    <= '0;
          if (bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized self-checking bench for id_ex_stage_reg against a per-edge
// behavioural model of the ID/EX register, hazard rule and bubble counter.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rt;
    logic [31:0] imm;
    logic        reg_wen;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        jr;
    logic [3:0]  alu_op;
  } stage_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_stall;
  logic        flush;
  logic        stall_out;
  logic        stall_out_sat;
  logic [15:0] bubble_cnt;
  logic [3:0]  bubble_cnt_sat;

  stage_t id_s;
  stage_t act;
  stage_t act_sat;
  stage_t exp_s;
  int     exp_cnt;
  int     n_vec;
  int     n_err;

  id_ex_stage_reg_if #(.DATA_W(32), .ALUOP_W(4)) id_if ();
  id_ex_stage_reg_if #(.DATA_W(32), .ALUOP_W(4)) ex_if ();
  id_ex_stage_reg_if #(.DATA_W(32), .ALUOP_W(4)) ex_if_sat ();

  id_ex_stage_reg #(.DATA_W(32), .ALUOP_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_bus     (id_if),
    .ex_bus     (ex_if),
    .ex_stall   (ex_stall),
    .flush      (flush),
    .stall_out  (stall_out),
    .bubble_cnt (bubble_cnt)
  );

  id_ex_stage_reg #(.DATA_W(32), .ALUOP_W(4), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_bus     (id_if),
    .ex_bus     (ex_if_sat),
    .ex_stall   (ex_stall),
    .flush      (flush),
    .stall_out  (stall_out_sat),
    .bubble_cnt (bubble_cnt_sat)
  );

  always #5 clk = ~clk;

  assign id_if.valid     = id_s.valid;
  assign id_if.pc        = id_s.pc;
  assign id_if.rs_data   = id_s.rs_data;
  assign id_if.rt_data   = id_s.rt_data;
  assign id_if.rs        = id_s.rs;
  assign id_if.rt        = id_s.rt;
  assign id_if.rd        = id_s.rd;
  assign id_if.uses_rt   = id_s.uses_rt;
  assign id_if.imm       = id_s.imm;
  assign id_if.reg_wen   = id_s.reg_wen;
  assign id_if.mem_read  = id_s.mem_read;
  assign id_if.mem_write = id_s.mem_write;
  assign id_if.alu_src   = id_s.alu_src;
  assign id_if.jr        = id_s.jr;
  assign id_if.alu_op    = id_s.alu_op;

  always_comb begin
    act = '0;
    act.valid = ex_if.valid;       act.pc = ex_if.pc;
    act.rs_data = ex_if.rs_data;   act.rt_data = ex_if.rt_data;
    act.rs = ex_if.rs;             act.rt = ex_if.rt;          act.rd = ex_if.rd;
    act.uses_rt = ex_if.uses_rt;   act.imm = ex_if.imm;
    act.reg_wen = ex_if.reg_wen;   act.mem_read = ex_if.mem_read;
    act.mem_write = ex_if.mem_write; act.alu_src = ex_if.alu_src;
    act.jr = ex_if.jr;             act.alu_op = ex_if.alu_op;
  end

  always_comb begin
    act_sat = '0;
    act_sat.valid = ex_if_sat.valid;       act_sat.pc = ex_if_sat.pc;
    act_sat.rs_data = ex_if_sat.rs_data;   act_sat.rt_data = ex_if_sat.rt_data;
    act_sat.rs = ex_if_sat.rs;             act_sat.rt = ex_if_sat.rt;
    act_sat.rd = ex_if_sat.rd;             act_sat.uses_rt = ex_if_sat.uses_rt;
    act_sat.imm = ex_if_sat.imm;           act_sat.reg_wen = ex_if_sat.reg_wen;
    act_sat.mem_read = ex_if_sat.mem_read; act_sat.mem_write = ex_if_sat.mem_write;
    act_sat.alu_src = ex_if_sat.alu_src;   act_sat.jr = ex_if_sat.jr;
    act_sat.alu_op = ex_if_sat.alu_op;
  end

  // Reference rule: a valid load in EX writing a non-zero register that ID reads.
  function automatic logic model_lu(input stage_t e, input stage_t i);
    return e.valid && e.mem_read && (e.rd != 5'd0) && i.valid &&
           ((e.rd == i.rs) || (i.uses_rt && (e.rd == i.rt)));
  endfunction

  function automatic logic model_stall();
    return ex_stall || (model_lu(exp_s, id_s) && !flush);
  endfunction

  function automatic int sat15(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic step();
    logic lu;
    lu = model_lu(exp_s, id_s);
    @(posedge clk);
    if (!ex_stall) begin
      if (flush || lu) begin
        exp_s = '0;
        exp_cnt++;
      end else begin
        exp_s = id_s;
      end
    end
    #1;
  endtask

  task automatic rand_id();
    id_s.valid     = ($urandom_range(0, 3) != 0);
    id_s.pc        = $urandom;
    id_s.rs_data   = $urandom;
    id_s.rt_data   = $urandom;
    id_s.rs        = 5'($urandom_range(0, 3));
    id_s.rt        = 5'($urandom_range(0, 3));
    id_s.rd        = 5'($urandom_range(0, 3));
    id_s.uses_rt   = 1'($urandom);
    id_s.imm       = $urandom;
    id_s.reg_wen   = 1'($urandom);
    id_s.mem_read  = ($urandom_range(0, 2) == 0);
    id_s.mem_write = 1'($urandom);
    id_s.alu_src   = 1'($urandom);
    id_s.jr        = 1'($urandom);
    id_s.alu_op    = 4'($urandom);
  endtask

  task automatic setup_load(input logic [4:0] rd);
    ex_stall = 1'b0;
    flush    = 1'b0;
    id_s          = '0;
    id_s.valid    = 1'b1;
    id_s.pc       = $urandom;
    id_s.rs       = 5'd29;
    id_s.rs_data  = $urandom;
    id_s.rd       = rd;
    id_s.imm      = $urandom;
    id_s.reg_wen  = 1'b1;
    id_s.mem_read = 1'b1;
    id_s.alu_src  = 1'b1;
    step();
  endtask

  task automatic set_alu(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt);
    rand_id();
    id_s.valid    = 1'b1;
    id_s.rs       = rs;
    id_s.rt       = rt;
    id_s.rd       = 5'd10;
    id_s.uses_rt  = uses_rt;
    id_s.mem_read = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    rand_id();
    exp_s = '0; exp_cnt = 0;
    #3;
    n_vec++;
    if (act !== stage_t'(0)) begin n_err++; $display("FAIL reset_ex: got %h want 0", act); end
    n_vec++;
    if (bubble_cnt !== 16'd0 || bubble_cnt_sat !== 4'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bubble_cnt, bubble_cnt_sat);
    end
    n_vec++;
    if (stall_out !== 1'b0) begin n_err++; $display("FAIL reset_stall_lo: got %b want 0", stall_out); end
    ex_stall = 1'b1;
    #1;
    n_vec++;
    if (stall_out !== 1'b1) begin n_err++; $display("FAIL reset_stall_hi: got %b want 1", stall_out); end
    ex_stall = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_load_use_rs();
    setup_load(5'd8);
    set_alu(5'd8, 5'd9, 1'b1);
    #1;
    n_vec++;
    if (stall_out !== 1'b1 || !model_stall()) begin
      n_err++; $display("FAIL lu_rs_stall: got %b want 1", stall_out);
    end
    step();
    n_vec++;
    if (act !== exp_s || act.valid !== 1'b0) begin
      n_err++; $display("FAIL lu_rs_bubble: got %h want %h", act, exp_s);
    end
    n_vec++;
    if (stall_out !== 1'b0) begin n_err++; $display("FAIL lu_rs_release: got %b want 0", stall_out); end
    step();
    n_vec++;
    if (act !== id_s || exp_s !== id_s) begin
      n_err++; $display("FAIL lu_rs_enter: got %h want %h", act, id_s);
    end
    n_vec++;
    if (bubble_cnt !== 16'(exp_cnt)) begin
      n_err++; $display("FAIL lu_rs_cnt: got %0d want %0d", bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_load_use_rt();
    setup_load(5'd8);
    set_alu(5'd9, 5'd8, 1'b1);
    id_s.mem_write = 1'b1;
    #1;
    n_vec++;
    if (stall_out !== 1'b1) begin n_err++; $display("FAIL lu_rt_stall: got %b want 1", stall_out); end
    step();
    n_vec++;
    if (act.valid !== 1'b0 || act !== exp_s) begin
      n_err++; $display("FAIL lu_rt_bubble: got %h want %h", act, exp_s);
    end
    setup_load(5'd8);
    set_alu(5'd9, 5'd8, 1'b0);
    #1;
    n_vec++;
    if (stall_out !== 1'b0) begin n_err++; $display("FAIL no_rt_stall: got %b want 0", stall_out); end
    step();
    n_vec++;
    if (act !== id_s) begin n_err++; $display("FAIL no_rt_enter: got %h want %h", act, id_s); end
  endtask

  task automatic test_zero_reg();
    int c0;
    setup_load(5'd0);
    set_alu(5'd0, 5'd0, 1'b1);
    c0 = exp_cnt;
    #1;
    n_vec++;
    if (stall_out !== 1'b0) begin n_err++; $display("FAIL zero_stall: got %b want 0", stall_out); end
    step();
    n_vec++;
    if (act !== id_s || bubble_cnt !== 16'(c0)) begin
      n_err++; $display("FAIL zero_enter: got %h cnt %0d want %h cnt %0d", act, bubble_cnt, id_s, c0);
    end
  endtask

  task automatic test_flush_priority();
    int c0;
    setup_load(5'd8);
    set_alu(5'd8, 5'd3, 1'b0);
    flush = 1'b1;
    c0 = exp_cnt;
    #1;
    n_vec++;
    if (stall_out !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", stall_out); end
    step();
    n_vec++;
    if (act !== stage_t'(0) || bubble_cnt !== 16'(c0 + 1)) begin
      n_err++; $display("FAIL flush_bubble: got %h cnt %0d want 0 cnt %0d", act, bubble_cnt, c0 + 1);
    end
    flush = 1'b0;
  endtask

  task automatic test_ex_stall();
    stage_t held;
    int     c0;
    setup_load(5'd8);
    set_alu(5'd8, 5'd9, 1'b1);
    ex_stall = 1'b1;
    flush    = 1'b1;
    held = exp_s;
    c0   = exp_cnt;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (stall_out !== 1'b1) begin n_err++; $display("FAIL exst_stall[%0d]: got %b want 1", i, stall_out); end
      step();
      n_vec++;
      if (act !== held || bubble_cnt !== 16'(c0)) begin
        n_err++; $display("FAIL exst_hold[%0d]: got %h cnt %0d want %h cnt %0d", i, act, bubble_cnt, held, c0);
      end
    end
    ex_stall = 1'b0;
    flush    = 1'b0;
    step();
    n_vec++;
    if (act !== exp_s || bubble_cnt !== 16'(exp_cnt)) begin
      n_err++; $display("FAIL exst_resume: got %h cnt %0d want %h cnt %0d", act, bubble_cnt, exp_s, exp_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_id();
      ex_stall = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      #1;
      n_vec++;
      if (stall_out !== model_stall() || stall_out_sat !== model_stall()) begin
        n_err++; $display("FAIL rnd_stall[%0d]: got %b/%b want %b", i, stall_out, stall_out_sat, model_stall());
      end
      step();
      n_vec++;
      if (act !== exp_s || act_sat !== exp_s) begin
        n_err++; $display("FAIL rnd_ex[%0d]: got %h want %h", i, act, exp_s);
      end
      n_vec++;
      if (bubble_cnt !== 16'(exp_cnt) || bubble_cnt_sat !== 4'(sat15(exp_cnt))) begin
        n_err++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, bubble_cnt, bubble_cnt_sat, exp_cnt, sat15(exp_cnt));
      end
    end
    ex_stall = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_saturation();
    rand_id();
    flush    = 1'b1;
    ex_stall = 1'b0;
    for (int i = 0; i < 20; i++) step();
    flush = 1'b0;
    n_vec++;
    if (bubble_cnt_sat !== 4'd15 || exp_cnt < 15) begin
      n_err++; $display("FAIL sat_cnt: got %0d want 15", bubble_cnt_sat);
    end
    n_vec++;
    if (bubble_cnt !== 16'(exp_cnt)) begin
      n_err++; $display("FAIL wide_cnt: got %0d want %0d", bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    setup_load(5'd8);
    set_alu(5'd8, 5'd9, 1'b1);
    #1;
    n_vec++;
    if (stall_out !== 1'b1) begin n_err++; $display("FAIL arst_pre_stall: got %b want 1", stall_out); end
    rst_n = 1'b0;
    exp_s = '0;
    exp_cnt = 0;
    #1;
    n_vec++;
    if (act !== stage_t'(0) || act_sat !== stage_t'(0)) begin
      n_err++; $display("FAIL arst_ex: got %h want 0", act);
    end
    n_vec++;
    if (bubble_cnt !== 16'd0 || bubble_cnt_sat !== 4'd0) begin
      n_err++; $display("FAIL arst_cnt: got %0d/%0d want 0/0", bubble_cnt, bubble_cnt_sat);
    end
    n_vec++;
    if (stall_out !== 1'b0) begin n_err++; $display("FAIL arst_stall: got %b want 0", stall_out); end
    #1 rst_n = 1'b1;
    step();
    n_vec++;
    if (act !== exp_s || act !== id_s) begin
      n_err++; $display("FAIL arst_resume: got %h want %h", act, id_s);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    id_s  = '0;
    test_reset();
    test_load_use_rs();
    test_load_use_rt();
    test_zero_reg();
    test_flush_priority();
    test_ex_stall();
    test_random();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
